// File: rtl/instr_prefetch_queue_pkg.sv
// Shared constants for the instruction prefetch queue: exception codes, FSM state
// encodings and the queue entry layout.
package instr_prefetch_queue_pkg;

  localparam int unsigned EXCEPTION_LEN = 2;

  localparam logic [EXCEPTION_LEN-1:0] EXCEP_OK                 = 2'd0;
  localparam logic [EXCEPTION_LEN-1:0] EXCEP_INSTR_MISALIGNED   = 2'd1;
  localparam logic [EXCEPTION_LEN-1:0] EXCEP_INSTR_ACCESS_FAULT = 2'd2;

  localparam logic [1:0] PF_IDLE  = 2'd0;
  localparam logic [1:0] PF_REQ   = 2'd1;
  localparam logic [1:0] PF_DRAIN = 2'd2;
  localparam logic [1:0] PF_HALT  = 2'd3;

  typedef enum logic [1:0] {
    StIdle  = PF_IDLE,
    StReq   = PF_REQ,
    StDrain = PF_DRAIN,
    StHalt  = PF_HALT
  } pf_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } pf_entry_t;

  function automatic logic [31:0] next_fetch_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/prefetch_fifo.sv
// Circular buffer of {pc, instr} entries with push, pop and a synchronous clear that
// dominates both. Head is read combinationally.
module prefetch_fifo
  import instr_prefetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  pf_entry_t                push_data,
  input  logic                     pop,
  output pf_entry_t                head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  pf_entry_t         mem [DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset; count gates every read of it.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr_q] <= push_data;
  end

  assign head  = mem[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: sequential single-outstanding fetches into a small FIFO,
// flush/redirect with drain of the in-flight word, precise fetch faults.
// Optional discard statistics are enabled by defining PREFETCH_STATS_EN.
module instr_prefetch_queue
  import instr_prefetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [31:0]              memAddr_Out,
  output logic                     memReq_Out,
  input  logic                     memAck_In,
  input  logic [31:0]              memData_In,
  input  logic                     memErr_In,
  output logic [31:0]              instr_Out,
  output logic [31:0]              pc_Out,
  output logic                     valid_Out,
  input  logic                     ready_In,
  input  logic [31:0]              pcWrite_In,
  input  logic                     pcFlush_In,
  output logic [EXCEPTION_LEN-1:0] exception_Out
`ifdef PREFETCH_STATS_EN
  ,
  output logic [31:0]              discardCount_Out
`endif
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  pf_state_e                state_q, state_d;
  logic [31:0]              fetch_pc_q, fetch_pc_d;
  logic [31:0]              drain_addr_q, drain_addr_d;
  logic [EXCEPTION_LEN-1:0] halt_q, halt_d;

  logic                     fifo_push;
  logic                     fifo_pop;
  pf_entry_t                fifo_head;
  logic [CW-1:0]            count;
  logic                     space;
  logic [CW:0]              occ_after;

  assign space     = count < CW'(DEPTH);
  assign fifo_pop  = (count != '0) && ready_In && !pcFlush_In;
  assign occ_after = {1'b0, count} + (CW+1)'(1) - (CW+1)'(fifo_pop);

  prefetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .clear    (pcFlush_In),
    .push     (fifo_push),
    .push_data('{pc: fetch_pc_q, instr: memData_In}),
    .pop      (fifo_pop),
    .head     (fifo_head),
    .count    (count)
  );

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    drain_addr_d = drain_addr_q;
    halt_d       = halt_q;
    fifo_push    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (fetch_pc_q[1:0] != 2'b00) begin
          state_d = StHalt;
          halt_d  = EXCEP_INSTR_MISALIGNED;
        end else if (space) begin
          state_d = StReq;
        end
      end
      StReq: begin
        if (memAck_In) begin
          if (memErr_In) begin
            state_d = StHalt;
            halt_d  = EXCEP_INSTR_ACCESS_FAULT;
          end else begin
            fifo_push  = 1'b1;
            fetch_pc_d = next_fetch_pc(fetch_pc_q);
            state_d    = (occ_after < (CW+1)'(DEPTH)) ? StReq : StIdle;
          end
        end
      end
      StDrain: begin
        if (memAck_In) state_d = StIdle;
      end
      StHalt: begin
      end
      default: state_d = StIdle;
    endcase

    // Redirect overrides push, pop and any fault raised this cycle.
    if (pcFlush_In) begin
      fifo_push  = 1'b0;
      fetch_pc_d = pcWrite_In;
      halt_d     = EXCEP_OK;
      if ((state_q == StReq && !memAck_In) || state_q == StDrain) begin
        state_d = StDrain;
      end else begin
        state_d = StIdle;
      end
      // The abandoned request keeps its address on the bus until acked.
      if (state_q == StReq) drain_addr_d = fetch_pc_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      fetch_pc_q   <= RESET_PC;
      drain_addr_q <= RESET_PC;
      halt_q       <= EXCEP_OK;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      drain_addr_q <= drain_addr_d;
      halt_q       <= halt_d;
    end
  end

  assign memReq_Out    = (state_q == StReq) || (state_q == StDrain);
  assign memAddr_Out   = (state_q == StDrain) ? drain_addr_q : fetch_pc_q;
  assign valid_Out     = count != '0;
  assign instr_Out     = valid_Out ? fifo_head.instr : 32'd0;
  assign pc_Out        = valid_Out ? fifo_head.pc : 32'd0;
  // A fault surfaces only once every older word has been consumed.
  assign exception_Out = (count == '0) ? halt_q : EXCEP_OK;

`ifdef PREFETCH_STATS_EN
  logic [31:0] discard_q;
  logic [33:0] discard_sum;

  always_comb begin
    discard_sum = {2'b00, discard_q}
                + (pcFlush_In ? 34'(count) : 34'd0)
                + 34'((state_q == StDrain) && memAck_In);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      discard_q <= '0;
    end else begin
      discard_q <= (discard_sum[33:32] != 2'b00) ? 32'hFFFF_FFFF : discard_sum[31:0];
    end
  end

  assign discardCount_Out = discard_q;
`endif

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Scoreboard bench for instr_prefetch_queue: directed phases push expected {pc, instr}
// pairs, a negedge monitor pops and compares every delivered word.
module tb_instr_prefetch_queue;
  import instr_prefetch_queue_pkg::*;

  localparam logic [31:0] K = 32'hA5A5_0000;

  logic                     clk = 1'b0;
  logic                     rst = 1'b0;
  logic [31:0]              memAddr_Out;
  logic                     memReq_Out;
  logic                     memAck_In = 1'b0;
  logic [31:0]              memData_In = '0;
  logic                     memErr_In = 1'b0;
  logic [31:0]              instr_Out;
  logic [31:0]              pc_Out;
  logic                     valid_Out;
  logic                     ready_In = 1'b0;
  logic [31:0]              pcWrite_In = '0;
  logic                     pcFlush_In = 1'b0;
  logic [EXCEPTION_LEN-1:0] exception_Out;
`ifdef PREFETCH_STATS_EN
  logic [31:0]              discard_count;
`endif

  instr_prefetch_queue #(
    .DEPTH   (4),
    .RESET_PC(32'h0000_0000)
  ) dut (
`ifdef PREFETCH_STATS_EN
    .discardCount_Out(discard_count),
`endif
    .clk          (clk),
    .rst          (rst),
    .memAddr_Out  (memAddr_Out),
    .memReq_Out   (memReq_Out),
    .memAck_In    (memAck_In),
    .memData_In   (memData_In),
    .memErr_In    (memErr_In),
    .instr_Out    (instr_Out),
    .pc_Out       (pc_Out),
    .valid_Out    (valid_Out),
    .ready_In     (ready_In),
    .pcWrite_In   (pcWrite_In),
    .pcFlush_In   (pcFlush_In),
    .exception_Out(exception_Out)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  logic [63:0] exp_q[$];
  logic [31:0] ack_limit = '0;
  logic [31:0] err_addr = '0;
  logic        err_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Memory model: acks any address below ack_limit one cycle after the request is seen.
  always @(posedge clk) begin
    #1;
    memAck_In  = memReq_Out && (memAddr_Out < ack_limit);
    memData_In = memAddr_Out ^ K;
    memErr_In  = memAck_In && err_en && (memAddr_Out == err_addr);
  end

  logic [63:0] mon_exp;
  always @(negedge clk) begin
    if (rst) begin
      if (valid_Out && ready_In && !pcFlush_In) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_word: got pc %h, expected none", pc_Out);
        end else begin
          mon_exp = exp_q.pop_front();
          check("deliver", {pc_Out, instr_Out}, mon_exp);
        end
      end else if (!valid_Out) begin
        check("empty_head_zero", {pc_Out, instr_Out}, 64'd0);
      end
    end
  end

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic expect_words(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] a;
      a = base + 32'(i * 4);
      exp_q.push_back({a, a ^ K});
    end
  endtask

  task automatic wait_empty(input int max, input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max) begin
      at_neg();
      n++;
    end
    check(name, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_req"}, 64'(memReq_Out), 64'd0);
    check({name, "_valid"}, 64'(valid_Out), 64'd0);
    check({name, "_head"}, {pc_Out, instr_Out}, 64'd0);
    check({name, "_exc"}, 64'(exception_Out), 64'(EXCEP_OK));
    check({name, "_addr"}, 64'(memAddr_Out), 64'd0);
  endtask

  task automatic do_reset(input logic rdy, input logic [31:0] lim);
    rst        = 1'b0;
    ready_In   = rdy;
    ack_limit  = lim;
    pcFlush_In = 1'b0;
    err_en     = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    // Streaming: one word per cycle, first word valid after the second edge.
    ready_In  = 1'b1;
    ack_limit = 32'h20;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    expect_words(32'h0, 8);
    @(negedge clk);
    rst = 1'b1;
    at_neg();
    check("first_req", 64'(memReq_Out), 64'd1);
    check("first_not_valid", 64'(valid_Out), 64'd0);
    at_neg();
    check("first_valid", 64'(valid_Out), 64'd1);
    repeat (7) at_neg();
    check("stream_rate", 64'(exp_q.size()), 64'd0);
    check("stream_stall_addr", 64'(memAddr_Out), 64'h20);
    exp_q.delete();

    // Full queue with consumer stalled, then resume.
    do_reset(1'b0, 32'h20);
    cyc(12);
    check("full_no_req", 64'(memReq_Out), 64'd0);
    check("full_head", {pc_Out, instr_Out}, {32'h0, K});
    expect_words(32'h0, 8);
    ready_In = 1'b1;
    for (int n = 0; n < 10 && !memReq_Out; n++) at_neg();
    check("resume_addr", 64'(memAddr_Out), 64'h10);
    wait_empty(40, "full_drain");
    check("full_end_addr", 64'(memAddr_Out), 64'h20);

    // Flush while a request is outstanding: stale request drained, data discarded.
    do_reset(1'b0, 32'h8);
    cyc(6);
    check("pre_flush_addr", 64'(memAddr_Out), 64'h8);
    check("pre_flush_req", 64'(memReq_Out), 64'd1);
    pcWrite_In = 32'h100;
    pcFlush_In = 1'b1;
    cyc(1);
    pcFlush_In = 1'b0;
    for (int i = 0; i < 3; i++) begin
      at_neg();
      check("drain_addr_held", 64'(memAddr_Out), 64'h8);
      check("drain_req_held", 64'(memReq_Out), 64'd1);
      check("drain_not_valid", 64'(valid_Out), 64'd0);
    end
    expect_words(32'h100, 16);
    ack_limit = 32'h140;
    ready_In  = 1'b1;
    wait_empty(80, "redirect_words");
`ifdef PREFETCH_STATS_EN
    check("discard_count", 64'(discard_count), 64'd3);
`endif

    // Misaligned redirect, then recovery.
    do_reset(1'b1, 32'h0);
    pcWrite_In = 32'h102;
    pcFlush_In = 1'b1;
    @(posedge clk);
    #2;
    pcFlush_In = 1'b0;
    at_neg();
    check("misalign_exc_early", 64'(exception_Out), 64'(EXCEP_OK));
    at_neg();
    check("misalign_exc", 64'(exception_Out), 64'(EXCEP_INSTR_MISALIGNED));
    repeat (4) at_neg();
    check("halt_no_req", 64'(memReq_Out), 64'd0);
    check("halt_exc_hold", 64'(exception_Out), 64'(EXCEP_INSTR_MISALIGNED));
    ack_limit = 32'h210;
    expect_words(32'h200, 4);
    @(posedge clk);
    #2;
    pcWrite_In = 32'h200;
    pcFlush_In = 1'b1;
    cyc(1);
    pcFlush_In = 1'b0;
    at_neg();
    check("recover_exc", 64'(exception_Out), 64'(EXCEP_OK));
    wait_empty(30, "recover_words");

    // Bus error on 0xC: older words delivered first, then the fault.
    do_reset(1'b0, 32'h10);
    err_addr = 32'hC;
    err_en   = 1'b1;
    cyc(10);
    check("fault_no_req", 64'(memReq_Out), 64'd0);
    check("fault_hidden", 64'(exception_Out), 64'(EXCEP_OK));
    check("fault_valid", 64'(valid_Out), 64'd1);
    expect_words(32'h0, 3);
    ready_In = 1'b1;
    wait_empty(10, "fault_words");
    cyc(1);
    check("fault_exc", 64'(exception_Out), 64'(EXCEP_INSTR_ACCESS_FAULT));
    check("fault_still_no_req", 64'(memReq_Out), 64'd0);
    err_en = 1'b0;

    // Asynchronous reset in the middle of a request.
    do_reset(1'b0, 32'h8);
    cyc(6);
    check("pre_reset_valid", 64'(valid_Out), 64'd1);
    check("pre_reset_req", 64'(memReq_Out), 64'd1);
    @(negedge clk);
    #3;
    rst = 1'b0;
    #1;
    check_reset_outputs("async_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1);
  end

endmodule
